jtrthunder_gfxarb: RTL

- Sequences and shares the single graphics-ROM (SDRAM bank) port among three video fetchers: scroll layer 0, scroll layer 1 and object engine.
- Sits between those fetchers and the SDRAM controller inside the Rolling Thunder video subsystem.
- Uses round-robin arbitration, with object priority during horizontal blank.
- Keeps a per-requester last-word cache and a response watchdog.

---
 rtl/jtrthunder_gfxarb.sv | 134 +++++++++++++
 1 files changed

// File: rtl/jtrthunder_gfxarb.sv
// jtrthunder_gfxarb: shares the graphics ROM port among scr0, scr1 and obj.
// Round-robin with obj-first in blank, per-port last-word cache, watchdog.
module jtrthunder_gfxarb #(
  parameter int AW  = 18,
  parameter int DW  = 32,
  parameter int TMO = 63
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            lhbl,
  input  logic [2:0]      rq_cs,
  input  logic [3*AW-1:0] rq_addr,
  output logic [2:0]      rq_ok,
  output logic [DW-1:0]   rq_data,
  output logic            rom_cs,
  output logic [AW-1:0]   rom_addr,
  input  logic            rom_ok,
  input  logic [DW-1:0]   rom_data,
  output logic            busy,
  output logic            tmo_err
);

  localparam int WW = $clog2(TMO + 1);

  typedef enum logic [1:0] {
    IDLE, GRANT, WAIT, DONE
  } st_t;

  st_t                  st;
  logic [1:0]           gnt;
  logic [1:0]           rr;
  logic [WW-1:0]        wd;
  logic [2:0][AW-1:0]   last_addr;
  logic [2:0][DW-1:0]   last_data;
  logic [2:0]           valid;
  logic [2:0]           rq_ok_q;
  logic [2:0][AW-1:0]   addr;
  logic [2:0]           pend;
  logic                 hit_any;
  logic [1:0]           hit_sel;
  logic [1:0]           g_sel;

  function automatic logic [1:0] wrap3(
    input logic [1:0] a,
    input int         k
  );
    int s;
    s = int'(a) + k;
    return 2'(s % 3);
  endfunction

  assign addr    = rq_addr;
  assign rq_ok   = rq_ok_q;
  assign busy    = (st == GRANT) || (st == WAIT);

  // A requester whose ok is on the wire right now is not pending yet.
  assign pend    = rq_cs & ~rq_ok_q;

  always_comb begin
    hit_any = 1'b0;
    hit_sel = 2'd0;
    g_sel   = rr;
    for (int i = 2; i >= 0; i--) begin
      if (pend[i] && valid[i] && last_addr[i] == addr[i]) begin
        hit_any = 1'b1;
        hit_sel = 2'(i);
      end
    end
    for (int k = 2; k >= 0; k--) begin
      if (pend[wrap3(rr, k)]) g_sel = wrap3(rr, k);
    end
    if (!lhbl && pend[2]) g_sel = 2'd2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= IDLE;
      gnt       <= 2'd0;
      rr        <= 2'd0;
      wd        <= '0;
      valid     <= 3'b000;
      last_addr <= '0;
      last_data <= '0;
      rq_ok_q   <= 3'b000;
      rq_data   <= '0;
      rom_cs    <= 1'b0;
      rom_addr  <= '0;
      tmo_err   <= 1'b0;
    end else begin
      rq_ok_q <= 3'b000;
      unique case (st)
        IDLE: begin
          if (hit_any) begin
            rq_ok_q[hit_sel] <= 1'b1;
            rq_data          <= last_data[hit_sel];
          end else if (|pend) begin
            gnt      <= g_sel;
            rom_addr <= addr[g_sel];
            rom_cs   <= 1'b1;
            st       <= GRANT;
          end
        end
        GRANT: begin
          wd <= '0;
          st <= WAIT;
        end
        WAIT: begin
          if (rom_ok) begin
            rom_cs         <= 1'b0;
            valid[gnt]     <= 1'b1;
            last_addr[gnt] <= rom_addr;
            last_data[gnt] <= rom_data;
            rq_ok_q[gnt]   <= 1'b1;
            rq_data        <= rom_data;
            rr             <= wrap3(gnt, 1);
            st             <= DONE;
          end else if (wd == WW'(TMO - 1)) begin
            // give up: release the fetcher with zero data, keep cache as is
            rom_cs       <= 1'b0;
            tmo_err      <= 1'b1;
            rq_ok_q[gnt] <= 1'b1;
            rq_data      <= '0;
            st           <= DONE;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        DONE: st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  end

endmodule
